crc_rr_scheduler: RTL

- Shares one bit-serial CRC-32 engine among NUM_REQ requesters using round-robin arbitration.
- Each requester offers one 32-bit word per valid/ready handshake.
- The scheduler latches the word and the polynomial, then sequences 32 shift cycles.
- It returns the remainder with the winning requester's ID on a valid/ready response channel. It sits between the bus-facing request queues and the CRC datapath.

---
 rtl/crc_sched_pkg.sv | 30 +++
 rtl/crc_serial_core.sv | 44 ++++
 rtl/crc_rr_scheduler.sv | 127 ++++++++++++
 3 files changed

// File: rtl/crc_sched_pkg.sv
// Shared definitions for the round-robin CRC-32 scheduler: datapath width,
// default polynomial, FSM state type and the round-robin pick helper.
package crc_sched_pkg;

    localparam int CRC_W = 32;
    localparam logic [CRC_W-1:0] CRC32_DEFAULT_POLY = 32'h04C11DB7;
    localparam int MAX_REQ = 16;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} sched_state_t;

    // Returns the first set bit of valid at or after ptr, wrapping modulo numReq.
    // When nothing is valid the pointer itself comes back; callers qualify
    // the result with the OR of the valid bits.
    function automatic int rr_pick(input logic [MAX_REQ-1:0] valid, input int ptr, input int numReq);
        int winner;
        int idx;
        logic found;
        winner = ptr;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            idx = (ptr + i) % numReq;
            if (!found && (i < numReq) && valid[4'(idx)]) begin
                winner = idx;
                found = 1'b1;
            end
        end
        return winner;
    endfunction

endpackage

// File: rtl/crc_serial_core.sv
// Bit-serial CRC-32 datapath: holds the running remainder and the polynomial
// captured at load time, and performs one MSB-first shift step per cycle.
module crc_serial_core
    import crc_sched_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [CRC_W-1:0] data_i,
    input  logic [CRC_W-1:0] poly_i,
    output logic [CRC_W-1:0] rem_o
);

    logic [CRC_W-1:0] rem_q;
    logic [CRC_W-1:0] rem_d;
    logic [CRC_W-1:0] poly_q;

    // Next remainder: load the message, or divide by one bit position.
    always_comb begin
        rem_d = rem_q;
        if (load_i) begin
            rem_d = data_i;
        end else if (shift_i) begin
            rem_d = rem_q[CRC_W-1] ? ((rem_q << 1) ^ poly_q) : (rem_q << 1);
        end
    end

    // Remainder and polynomial registers; the polynomial is frozen per job.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rem_q  <= '0;
            poly_q <= '0;
        end else begin
            rem_q <= rem_d;
            if (load_i) begin
                poly_q <= poly_i;
            end
        end
    end

    assign rem_o = rem_q;

endmodule

// File: rtl/crc_rr_scheduler.sv
// Round-robin scheduler sharing one bit-serial CRC-32 engine among NUM_REQ
// requesters. Optional completion counter enabled by CRC_SCHED_STATS_EN.
module crc_rr_scheduler
    import crc_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ*CRC_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic [CRC_W-1:0]         poly_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [CRC_W-1:0]         rsp_crc_o,
    output logic [ID_W-1:0]          rsp_id_o,
    output logic                     busy_o
`ifdef CRC_SCHED_STATS_EN
    ,
    input  logic                     stats_clr_i,
    output logic [15:0]              done_cnt_o
`endif
);

    sched_state_t     state_q;
    logic [4:0]       cnt_q;
    logic [ID_W-1:0]  ptr_q;
    logic [ID_W-1:0]  ptr_d;
    logic [ID_W-1:0]  id_q;
    logic             rsp_valid_q;
    logic [CRC_W-1:0] rsp_crc_q;
    logic [ID_W-1:0]  winner;
    logic             accept;
    logic             rsp_fire;
    logic [CRC_W-1:0] core_rem;

    // Arbitration is purely combinational so the grant appears in the same
    // IDLE cycle the request is seen; reset masks it so no grant leaks out.
    always_comb begin
        winner = ID_W'(rr_pick(MAX_REQ'(req_valid_i), int'(ptr_q), NUM_REQ));
        accept = (state_q == IDLE) && (|req_valid_i) && !rst_i;
        ptr_d  = (int'(winner) == NUM_REQ - 1) ? '0 : winner + ID_W'(1);
    end

    assign req_ready_o = accept ? (NUM_REQ'(1) << winner) : '0;
    assign rsp_fire    = rsp_valid_q && rsp_ready_i;

    crc_serial_core u_core (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (accept),
        .shift_i (state_q == SHIFT),
        .data_i  (req_data_i[int'(winner)*CRC_W +: CRC_W]),
        .poly_i  (poly_i),
        .rem_o   (core_rem)
    );

    // Job sequencing: accept, 32 shift cycles, then a DONE phase whose first
    // cycle captures the finished remainder into the response registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ptr_q       <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_crc_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        ptr_q   <= ptr_d;
                        id_q    <= winner;
                        cnt_q   <= 5'd31;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    cnt_q <= cnt_q - 5'd1;
                    if (cnt_q == 5'd0) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (!rsp_valid_q) begin
                        rsp_valid_q <= 1'b1;
                        rsp_crc_q   <= core_rem;
                    end else if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_crc_o   = rsp_crc_q;
    assign rsp_id_o    = id_q;
    assign busy_o      = (state_q != IDLE);

`ifdef CRC_SCHED_STATS_EN
    logic [15:0] done_cnt_q;

    // Saturating count of completed response handshakes; clear wins.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            done_cnt_q <= '0;
        end else if (stats_clr_i) begin
            done_cnt_q <= '0;
        end else if (rsp_fire && (done_cnt_q != 16'hFFFF)) begin
            done_cnt_q <= done_cnt_q + 16'd1;
        end
    end

    assign done_cnt_o = done_cnt_q;
`else
    logic unusedFire;
    assign unusedFire = rsp_fire;
`endif

endmodule
